// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain-compensation factor and
// pipeline latency. Used by both cordic_vectoring and cordic_rotation.
package cordic_pkg;

    // atan(2^-i) / (2*pi) * 2^32, i.e. the angle as a fraction of a full turn
    // in 32-bit binary angle units.
    function automatic logic [31:0] atan_full(input int i);
        logic [31:0] v;
        case (i)
            0:  v = 32'd536870912;
            1:  v = 32'd316933406;
            2:  v = 32'd167458907;
            3:  v = 32'd85004756;
            4:  v = 32'd42667331;
            5:  v = 32'd21354465;
            6:  v = 32'd10679838;
            7:  v = 32'd5340245;
            8:  v = 32'd2670163;
            9:  v = 32'd1335087;
            10: v = 32'd667544;
            11: v = 32'd333772;
            12: v = 32'd166886;
            13: v = 32'd83443;
            14: v = 32'd41722;
            15: v = 32'd20861;
            16: v = 32'd10430;
            17: v = 32'd5215;
            18: v = 32'd2608;
            19: v = 32'd1304;
            20: v = 32'd652;
            21: v = 32'd326;
            22: v = 32'd163;
            23: v = 32'd81;
            24: v = 32'd41;
            25: v = 32'd20;
            26: v = 32'd10;
            27: v = 32'd5;
            28: v = 32'd3;
            29: v = 32'd1;
            30: v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Table entry i reduced to an aw-bit angle, rounded to nearest.
    // The largest entry is 2^29, so the rounding add cannot overflow.
    function automatic logic [31:0] atan_slice(input int i, input int aw);
        return (atan_full(i) + (32'd1 << (31 - aw))) >> (32 - aw);
    endfunction

    // round(2^15 / K_n) with K_n = prod_{i<n} sqrt(1 + 2^-2i).
    // K_n has converged to 15-bit precision from n = 10 onward.
    function automatic int kinv_of(input int n);
        int v;
        case (n)
            1:  v = 23170;
            2:  v = 20724;
            3:  v = 20106;
            4:  v = 19950;
            5:  v = 19911;
            6:  v = 19902;
            7:  v = 19899;
            8:  v = 19899;
            9:  v = 19899;
            default: v = 19898;
        endcase
        return v;
    endfunction

    // Pre-rotation, one register per micro-rotation, optional scaling, output.
    function automatic int latency_of(input int iterations, input int comp);
        return iterations + 2 + ((comp != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/cordic_vectoring_stage.sv
// One vectoring micro-rotation: drives y toward zero by rotating by
// +/-atan(2^-STAGE) and accumulates the applied angle in z. Also carries the
// valid and zero-input flags of the sample one stage forward.
module cordic_vectoring_stage
    import cordic_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int XW    = 18,
    parameter int AW    = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic                 zero_i,
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic        [AW-1:0] z_i,
    output logic                 valid_o,
    output logic                 zero_o,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic        [AW-1:0] z_o
);

    localparam logic [31:0]   ATAN_WIDE = atan_slice(STAGE, AW);
    localparam logic [AW-1:0] ATAN_I    = ATAN_WIDE[AW-1:0];

    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] x_d, y_d, x_q, y_q;
    logic        [AW-1:0] z_d, z_q;
    logic                 valid_q, zero_q;

    // Rotation direction follows the sign of y; both updates use stage inputs.
    always_comb begin
        x_sh = x_i >>> STAGE;
        y_sh = y_i >>> STAGE;
        x_d  = x_i;
        y_d  = y_i;
        z_d  = z_i;
        if (!y_i[XW-1]) begin
            x_d = x_i + y_sh;
            y_d = y_i - x_sh;
            z_d = z_i + ATAN_I;
        end else begin
            x_d = x_i - y_sh;
            y_d = y_i + x_sh;
            z_d = z_i - ATAN_I;
        end
    end

    // Stage registers; data loads every cycle, valid qualifies it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_i;
            zero_q  <= zero_i;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;
    assign valid_o = valid_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/cordic_vectoring.sv
// Pipelined CORDIC vectoring: (xin, yin) -> magnitude and phase, one sample
// per clock, no backpressure.
// Build option: define CORDIC_VECTORING_ROUND_EN to round theta to nearest
// (half up, wrapping at full circle); otherwise theta is truncated.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITERATIONS           = 7,
    parameter int DATA_WIDTH           = 16,
    parameter int COMPENSATION_SCALING = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] xin,
    input  logic signed [DATA_WIDTH-1:0] yin,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH+1:0] mag,
    output logic        [ITERATIONS:0]   theta
);

    localparam int XW    = DATA_WIDTH + 2;  // headroom for CORDIC gain
    localparam int AW    = ITERATIONS + 5;  // angle plus 4 guard bits
    localparam int TW    = ITERATIONS + 1;
    localparam int GUARD = AW - TW;
    localparam int KW    = 17;              // KINV < 2^15, kept positive when signed

    localparam logic [AW-1:0] Z_HALF = {1'b1, {(AW-1){1'b0}}};
`ifdef CORDIC_VECTORING_ROUND_EN
    localparam logic [AW-1:0] Z_RND  = AW'(1) << (GUARD - 1);
`else
    localparam logic [AW-1:0] Z_RND  = '0;
`endif

    // ---------------- Stage P: widen and fold left half-plane ----------------
    logic signed [XW-1:0] xin_ext, yin_ext;
    logic signed [XW-1:0] x_p_d, y_p_d, x_p_q, y_p_q;
    logic        [AW-1:0] z_p_d, z_p_q;
    logic                 zero_p_d, zero_p_q, vld_p_q;

    // A vector with x < 0 is turned by half a circle so the micro-rotations,
    // which only converge within +/-99 degrees, always start in the right half.
    always_comb begin
        xin_ext  = {{2{xin[DATA_WIDTH-1]}}, xin};
        yin_ext  = {{2{yin[DATA_WIDTH-1]}}, yin};
        zero_p_d = (xin == '0) && (yin == '0);
        x_p_d    = xin_ext;
        y_p_d    = yin_ext;
        z_p_d    = '0;
        if (xin_ext[XW-1]) begin
            x_p_d = -xin_ext;
            y_p_d = -yin_ext;
            z_p_d = Z_HALF;
        end
    end

    // Pre-rotation register; a valid sampled together with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_p_q    <= '0;
            y_p_q    <= '0;
            z_p_q    <= '0;
            zero_p_q <= 1'b0;
            vld_p_q  <= 1'b0;
        end else begin
            x_p_q    <= x_p_d;
            y_p_q    <= y_p_d;
            z_p_q    <= z_p_d;
            zero_p_q <= zero_p_d;
            vld_p_q  <= in_valid;
        end
    end

    // ---------------- Micro-rotation chain ----------------
    logic signed [XW-1:0] x_s    [0:ITERATIONS];
    logic signed [XW-1:0] y_s    [0:ITERATIONS];
    logic        [AW-1:0] z_s    [0:ITERATIONS];
    logic                 vld_s  [0:ITERATIONS];
    logic                 zero_s [0:ITERATIONS];

    assign x_s[0]    = x_p_q;
    assign y_s[0]    = y_p_q;
    assign z_s[0]    = z_p_q;
    assign vld_s[0]  = vld_p_q;
    assign zero_s[0] = zero_p_q;

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
        cordic_vectoring_stage #(
            .STAGE (i),
            .XW    (XW),
            .AW    (AW)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (vld_s[i]),
            .zero_i  (zero_s[i]),
            .x_i     (x_s[i]),
            .y_i     (y_s[i]),
            .z_i     (z_s[i]),
            .valid_o (vld_s[i+1]),
            .zero_o  (zero_s[i+1]),
            .x_o     (x_s[i+1]),
            .y_o     (y_s[i+1]),
            .z_o     (z_s[i+1])
        );
    end

    // ---------------- Stage C: optional gain compensation ----------------
    logic signed [XW-1:0] mag_pre;
    logic        [AW-1:0] z_pre;
    logic                 vld_pre, zero_pre;

    if (COMPENSATION_SCALING != 0) begin : g_comp
        localparam logic signed [KW-1:0] KINV = KW'(kinv_of(ITERATIONS));

        logic signed [XW+KW-1:0] prod;
        logic signed [XW-1:0]    mag_c_d, mag_c_q;
        logic        [AW-1:0]    z_c_q;
        logic                    vld_c_q, zero_c_q;

        assign prod    = (XW+KW)'(x_s[ITERATIONS]) * (XW+KW)'(KINV);
        assign mag_c_d = XW'(prod >>> 15);

        // Scaling register; angle and flags ride along unchanged.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mag_c_q  <= '0;
                z_c_q    <= '0;
                vld_c_q  <= 1'b0;
                zero_c_q <= 1'b0;
            end else begin
                mag_c_q  <= mag_c_d;
                z_c_q    <= z_s[ITERATIONS];
                vld_c_q  <= vld_s[ITERATIONS];
                zero_c_q <= zero_s[ITERATIONS];
            end
        end

        assign mag_pre  = mag_c_q;
        assign z_pre    = z_c_q;
        assign vld_pre  = vld_c_q;
        assign zero_pre = zero_c_q;
    end else begin : g_raw
        assign mag_pre  = x_s[ITERATIONS];
        assign z_pre    = z_s[ITERATIONS];
        assign vld_pre  = vld_s[ITERATIONS];
        assign zero_pre = zero_s[ITERATIONS];
    end

    // ---------------- Stage O: angle reduction and output ----------------
    logic [AW-1:0] z_rnd;
    logic [TW-1:0] theta_d;

    // Dropping the guard bits; the add wraps modulo full circle by width.
    always_comb begin
        z_rnd   = z_pre + Z_RND;
        theta_d = TW'(z_rnd >> GUARD);
    end

    // Output register; a zero input has no defined phase, so force 0/0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mag       <= '0;
            theta     <= '0;
        end else begin
            out_valid <= vld_pre;
            if (zero_pre) begin
                mag   <= '0;
                theta <= '0;
            end else begin
                mag   <= mag_pre;
                theta <= theta_d;
            end
        end
    end

endmodule
